grf_sb: RTL and testbench

Parametrised general register file with two write ports, per-read-port write-through bypass and a pending-write scoreboard. It sits in the decode stage of the pipelined datapath. Write port 0 carries the in-order pipeline writeback. Write port 1 carries writebacks from long-latency units (multiplier/divider result moves, future load-miss return). Busy bits let the hazard unit stall readers of a register whose long-latency result has not yet arrived.

---
 rtl/grf_pkg.sv | 15 +
 rtl/grf_scoreboard.sv | 54 +++++
 rtl/grf_sb.sv | 88 ++++++++
 tb/tb_grf_sb.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/grf_pkg.sv
// Shared constants and helpers for the general register file and its scoreboard.
package grf_pkg;

    localparam int unsigned GP_IDX_DEF  = 28;
    localparam logic [31:0] GP_INIT_DEF = 32'h0000_1000;
    localparam int unsigned SP_IDX_DEF  = 29;
    localparam logic [31:0] SP_INIT_DEF = 32'h0000_2ffc;
    localparam int unsigned REG_ZERO    = 0;

    // Lowest bit of port `port`'s field in a flat vector of `width`-bit fields.
    function automatic int unsigned slice_lo(input int unsigned port, input int unsigned width);
        return port * width;
    endfunction

endpackage

// File: rtl/grf_scoreboard.sv
// Pending long-latency write tracker: one busy bit per register, double-issue and
// write-collision error pulse, and a registered OR of all busy bits.
module grf_scoreboard
    import grf_pkg::*;
#(
    parameter int unsigned AW = 5
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               iss_v_i,
    input  logic [AW-1:0]      iss_a_i,
    input  logic               we1_i,
    input  logic [AW-1:0]      wa1_i,
    input  logic               col_i,
    output logic [2**AW-1:0]   busy_o,
    output logic               busy_any_o,
    output logic               waw_err_o
);

    localparam int unsigned Depth = 2**AW;

    logic [Depth-1:0] busy_q, busy_d;
    logic             busy_any_q;
    logic             waw_err_q;
    logic             set_v, retire_v, dbl_iss;

    always_comb begin
        set_v    = iss_v_i && (iss_a_i != AW'(REG_ZERO));
        retire_v = we1_i && (wa1_i != AW'(REG_ZERO));
        // Re-issue onto a bit being retired this cycle is a legal handoff, not an error.
        dbl_iss  = set_v && busy_q[iss_a_i] && !(retire_v && (wa1_i == iss_a_i));
        busy_d   = busy_q;
        if (retire_v) busy_d[wa1_i] = 1'b0;
        // Set after clear: the new issue is younger and wins.
        if (set_v) busy_d[iss_a_i] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            busy_q     <= '0;
            busy_any_q <= 1'b0;
            waw_err_q  <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            busy_any_q <= |busy_d;
            waw_err_q  <= dbl_iss || col_i;
        end
    end

    assign busy_o     = busy_q;
    assign busy_any_o = busy_any_q;
    assign waw_err_o  = waw_err_q;

endmodule

// File: rtl/grf_sb.sv
// Two-write-port register file with per-read-port write-through bypass and a
// pending-write scoreboard for long-latency results.
module grf_sb
    import grf_pkg::*;
#(
    parameter int unsigned DW      = 32,
    parameter int unsigned AW      = 5,
    parameter int unsigned NRD     = 2,
    parameter int unsigned GP_IDX  = GP_IDX_DEF,
    parameter logic [DW-1:0] GP_INIT = DW'(GP_INIT_DEF),
    parameter int unsigned SP_IDX  = SP_IDX_DEF,
    parameter logic [DW-1:0] SP_INIT = DW'(SP_INIT_DEF)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [NRD*AW-1:0] ra,
    output logic [NRD*DW-1:0] rd,
    output logic [NRD-1:0]    rbusy,
    input  logic              we0,
    input  logic [AW-1:0]     wa0,
    input  logic [DW-1:0]     wd0,
    input  logic              we1,
    input  logic [AW-1:0]     wa1,
    input  logic [DW-1:0]     wd1,
    input  logic              iss_v,
    input  logic [AW-1:0]     iss_a,
    output logic              waw_err,
    output logic              busy_any
);

    localparam int unsigned Depth = 2**AW;

    logic [DW-1:0]    mem_q [Depth];
    logic [Depth-1:0] busy;
    logic             wr0_v, wr1_v, col;

    assign wr0_v = we0 && (wa0 != AW'(REG_ZERO));
    assign wr1_v = we1 && (wa1 != AW'(REG_ZERO));
    assign col   = wr0_v && wr1_v && (wa0 == wa1);

    // Port 0 is written last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int k = 0; k < Depth; k++) begin
                if (k == GP_IDX)      mem_q[k] <= GP_INIT;
                else if (k == SP_IDX) mem_q[k] <= SP_INIT;
                else                  mem_q[k] <= '0;
            end
        end else begin
            if (wr1_v) mem_q[wa1] <= wd1;
            if (wr0_v) mem_q[wa0] <= wd0;
        end
    end

    grf_scoreboard #(
        .AW(AW)
    ) u_scoreboard (
        .clk       (clk),
        .clr       (clr),
        .iss_v_i   (iss_v),
        .iss_a_i   (iss_a),
        .we1_i     (we1),
        .wa1_i     (wa1),
        .col_i     (col),
        .busy_o    (busy),
        .busy_any_o(busy_any),
        .waw_err_o (waw_err)
    );

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] addr;
        logic [DW-1:0] data;

        assign addr = ra[slice_lo(i, AW) +: AW];

        always_comb begin
            if (addr == AW'(REG_ZERO))       data = '0;
            else if (we0 && (wa0 == addr))   data = wd0;
            else if (we1 && (wa1 == addr))   data = wd1;
            else                             data = mem_q[addr];
        end

        assign rd[slice_lo(i, DW) +: DW] = data;
        // busy[0] never sets, so address 0 reads as not busy.
        assign rbusy[i] = busy[addr] && !(we1 && (wa1 == addr));
    end

endmodule

// File: tb/tb_grf_sb.sv
// Self-checking bench for grf_sb: directed scenarios plus randomized traffic against
// an array-based reference model of the register file and its busy bits.
module tb_grf_sb;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int NRD = 2;

    logic              clk;
    logic              clr;
    logic [NRD*AW-1:0] ra;
    logic [NRD*DW-1:0] rd;
    logic [NRD-1:0]    rbusy;
    logic              we0, we1, iss_v;
    logic [AW-1:0]     wa0, wa1, iss_a;
    logic [DW-1:0]     wd0, wd1;
    logic              waw_err, busy_any;

    grf_sb dut (
        .clk     (clk),
        .clr     (clr),
        .ra      (ra),
        .rd      (rd),
        .rbusy   (rbusy),
        .we0     (we0),
        .wa0     (wa0),
        .wd0     (wd0),
        .we1     (we1),
        .wa1     (wa1),
        .wd1     (wd1),
        .iss_v   (iss_v),
        .iss_a   (iss_a),
        .waw_err (waw_err),
        .busy_any(busy_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] m_mem  [32];
    logic        m_busy [32];
    logic        m_err;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 32; k++) begin
            m_mem[k]  = 32'h0;
            m_busy[k] = 1'b0;
        end
        m_mem[28] = 32'h0000_1000;
        m_mem[29] = 32'h0000_2ffc;
        m_err     = 1'b0;
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 0)                 return 32'h0;
        if (we0 && wa0 == a)        return wd0;
        if (we1 && wa1 == a)        return wd1;
        return m_mem[a];
    endfunction

    function automatic logic exp_any();
        for (int k = 0; k < 32; k++) if (m_busy[k]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_edge();
        logic err;
        if (clr) begin
            model_reset();
        end else begin
            err = (we0 && we1 && wa0 == wa1 && wa0 != 0) ||
                  (iss_v && iss_a != 0 && m_busy[iss_a] && !(we1 && wa1 == iss_a));
            if (we1 && wa1 != 0) m_mem[wa1] = wd1;
            if (we0 && wa0 != 0) m_mem[wa0] = wd0;
            if (we1 && wa1 != 0) m_busy[wa1] = 1'b0;
            if (iss_v && iss_a != 0) m_busy[iss_a] = 1'b1;
            m_err = err;
        end
    endtask

    task automatic check_outputs();
        logic [4:0] a;
        for (int p = 0; p < NRD; p++) begin
            a = ra[p*AW +: AW];
            check($sformatf("rd%0d[a=%0d]", p, a), 64'(rd[p*DW +: DW]), 64'(exp_rd(a)));
            check($sformatf("rbusy%0d[a=%0d]", p, a), 64'(rbusy[p]),
                  64'(a != 0 && m_busy[a] && !(we1 && wa1 == a)));
        end
        check("busy_any", 64'(busy_any), 64'(exp_any()));
        check("waw_err", 64'(waw_err), 64'(m_err));
    endtask

    task automatic cycle();
        #1 check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        clr = 0; we0 = 0; we1 = 0; iss_v = 0;
        wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0; iss_a = 0; ra = 0;
    endtask

    function automatic logic [4:0] rand_a();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    initial begin
        idle();
        clr = 1;
        @(posedge clk);
        model_reset();
        #1 clr = 0;

        // Reset values
        ra = {5'd29, 5'd28};
        #1 check("reset_gp", 64'(rd[31:0]), 64'h1000);
        check("reset_sp", 64'(rd[63:32]), 64'h2ffc);
        check("reset_busy_any", 64'(busy_any), 64'h0);
        check("reset_waw_err", 64'(waw_err), 64'h0);
        cycle();
        ra = {5'd0, 5'd5};
        #1 check("reset_r5", 64'(rd[31:0]), 64'h0);
        cycle();

        // Bypass and write-through
        we0 = 1; wa0 = 8; wd0 = 32'hDEAD_BEEF; ra = {5'd0, 5'd8};
        #1 check("bypass_same_cycle", 64'(rd[31:0]), 64'hDEAD_BEEF);
        cycle();
        we0 = 0;
        #1 check("bypass_after_edge", 64'(rd[31:0]), 64'hDEAD_BEEF);
        cycle();
        we0 = 1; wa0 = 0; wd0 = 32'h1234; ra = 0;
        #1 check("bypass_r0", 64'(rd[31:0]), 64'h0);
        cycle();

        // Dual write collision
        idle();
        we0 = 1; we1 = 1; wa0 = 9; wa1 = 9; wd0 = 1; wd1 = 2;
        cycle();
        idle(); ra = {5'd0, 5'd9};
        #1 check("collide_data", 64'(rd[31:0]), 64'h1);
        check("collide_err", 64'(waw_err), 64'h1);
        cycle();
        #1 check("collide_err_drop", 64'(waw_err), 64'h0);
        cycle();

        // Scoreboard issue / retire
        iss_v = 1; iss_a = 10;
        cycle();
        idle(); ra = {5'd10, 5'd0};
        #1 check("sb_rbusy", 64'(rbusy[1]), 64'h1);
        check("sb_busy_any", 64'(busy_any), 64'h1);
        cycle();
        we1 = 1; wa1 = 10; wd1 = 32'h55;
        #1 check("sb_retire_rbusy", 64'(rbusy[1]), 64'h0);
        check("sb_retire_data", 64'(rd[63:32]), 64'h55);
        cycle();
        idle();
        #1 check("sb_any_clear", 64'(busy_any), 64'h0);
        cycle();

        // Issue/retire race, then double issue
        iss_v = 1; iss_a = 11;
        cycle();
        we1 = 1; wa1 = 11; wd1 = 3;
        cycle();
        idle(); ra = {5'd0, 5'd11};
        #1 check("race_busy", 64'(rbusy[0]), 64'h1);
        check("race_no_err", 64'(waw_err), 64'h0);
        cycle();
        iss_v = 1; iss_a = 11;
        cycle();
        idle();
        #1 check("dbl_issue_err", 64'(waw_err), 64'h1);
        cycle();

        // Reset mid-operation
        iss_v = 1; iss_a = 12;
        cycle();
        idle(); clr = 1;
        cycle();
        clr = 0;
        #1 check("mid_reset_any", 64'(busy_any), 64'h0);
        we1 = 1; wa1 = 12; wd1 = 32'h77;
        cycle();
        idle(); ra = {5'd0, 5'd12};
        #1 check("mid_reset_data", 64'(rd[31:0]), 64'h77);
        check("mid_reset_no_err", 64'(waw_err), 64'h0);
        cycle();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            clr   = ($urandom_range(0, 63) == 0);
            we0   = 1'($urandom_range(0, 1));
            we1   = 1'($urandom_range(0, 1));
            iss_v = 1'($urandom_range(0, 1));
            wa0   = rand_a();
            wa1   = rand_a();
            iss_a = rand_a();
            wd0   = $urandom;
            wd1   = $urandom;
            ra    = {rand_a(), rand_a()};
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
